// File: rtl/disp_scheduler.sv
// disp_scheduler: mode controller for the six-digit multiplexed display.
// Chooses the BCD source feeding q0..q5, debounces the mode key, blinks the
// digit under edit and pre-empts everything with a blinking alarm-ring view.

// One display digit: registered source nibble, or blank (4'hF) when asked.
module disp_digit (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic [3:0] src,
  input  logic       blank,
  output logic [3:0] q
);

  // Output register; blank code also serves as the reset value.
  always_ff @(posedge clk1khz) begin
    if (rst)        q <= 4'hF;
    else if (blank) q <= 4'hF;
    else            q <= src;
  end

endmodule

module disp_scheduler #(
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HALF  = 250,
  parameter int RING_MS     = 2000
) (
  input  logic        clk1khz,
  input  logic        rst,
  input  logic        key_mode,
  input  logic [23:0] time_bcd,
  input  logic [23:0] sw_bcd,
  input  logic [23:0] alm_bcd,
  input  logic        edit_en,
  input  logic [2:0]  edit_pos,
  input  logic        alarm_req,
  output logic [3:0]  q0,
  output logic [3:0]  q1,
  output logic [3:0]  q2,
  output logic [3:0]  q3,
  output logic [3:0]  q4,
  output logic [3:0]  q5,
  output logic [1:0]  mode,
  output logic        ring_ack
);

  localparam int NUM_DIGITS = 6;
  localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int BL_W = $clog2(2 * BLINK_HALF);
  localparam int RG_W = $clog2(RING_MS + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_MS);
  localparam logic [DB_W-1:0] DB_ARM  = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [BL_W-1:0] BL_HALF = BL_W'(BLINK_HALF);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(2 * BLINK_HALF - 1);
  localparam logic [RG_W-1:0] RG_LAST = RG_W'(RING_MS - 1);

  typedef enum logic [1:0] {
    M_TIME   = 2'd0,
    M_SW     = 2'd1,
    M_ALMSET = 2'd2,
    M_RING   = 2'd3
  } mode_t;

  mode_t           state, state_nxt;
  mode_t           saved, saved_nxt;
  logic [RG_W-1:0] ring_cnt, ring_cnt_nxt;
  logic            ack_nxt;

  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            alarm_d;
  logic            ring_edge;
  logic [BL_W-1:0] blink_cnt;
  logic            blink_off;

  logic [NUM_DIGITS-1:0][3:0] src_bus;
  logic [NUM_DIGITS-1:0]      blank_bus;
  logic [NUM_DIGITS-1:0][3:0] q_bus;

  // ---------------------------------------------------------------------
  // Key debounce: count consecutive high samples, saturate at the target.
  // The press fires only on the step into saturation, so a held key (even
  // one held across a RING exit) yields a single press.
  // ---------------------------------------------------------------------

  // Debounce counter: cleared by any low sample, saturates at DB_MAX.
  always_ff @(posedge clk1khz) begin
    if (rst)                  db_cnt <= '0;
    else if (!key_mode)       db_cnt <= '0;
    else if (db_cnt != DB_MAX) db_cnt <= db_cnt + DB_W'(1);
  end

  assign press = key_mode && (db_cnt == DB_ARM);

  // ---------------------------------------------------------------------
  // Alarm rising edge. alarm_d resets low, so a level already high when
  // reset releases is treated as a fresh edge.
  // ---------------------------------------------------------------------

  // Delayed copy of the alarm level for edge detection.
  always_ff @(posedge clk1khz) begin
    if (rst) alarm_d <= 1'b0;
    else     alarm_d <= alarm_req;
  end

  assign ring_edge = alarm_req & ~alarm_d;

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------

  // State, return mode, ring timer and dismissal pulse registers.
  always_ff @(posedge clk1khz) begin
    if (rst) begin
      state    <= M_TIME;
      saved    <= M_TIME;
      ring_cnt <= '0;
      ring_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      saved    <= saved_nxt;
      ring_cnt <= ring_cnt_nxt;
      ring_ack <= ack_nxt;
    end
  end

  // Next-state logic. An alarm edge outranks (and swallows) a press outside
  // RING; inside RING a press beats alarm drop, which beats the timeout.
  always_comb begin
    state_nxt    = state;
    saved_nxt    = saved;
    ring_cnt_nxt = ring_cnt;
    ack_nxt      = 1'b0;
    if (state != M_RING) begin
      if (ring_edge) begin
        state_nxt    = M_RING;
        saved_nxt    = state;
        ring_cnt_nxt = '0;
      end else if (press) begin
        case (state)
          M_TIME:  state_nxt = M_SW;
          M_SW:    state_nxt = M_ALMSET;
          default: state_nxt = M_TIME;
        endcase
      end
    end else begin
      ring_cnt_nxt = ring_cnt + RG_W'(1);
      if (press) begin
        state_nxt = saved;
        ack_nxt   = 1'b1;
      end else if (!alarm_req) begin
        state_nxt = saved;
      end else if (ring_cnt == RG_LAST) begin
        state_nxt = saved;
      end
    end
  end

  assign mode = state;

  // ---------------------------------------------------------------------
  // Blink phase: free-running over one full period, restarted on every mode
  // change so a new view always opens in the visible half. edit_pos is not
  // involved, so moving the cursor keeps the current phase.
  // ---------------------------------------------------------------------

  // Blink counter with wrap and restart on mode change.
  always_ff @(posedge clk1khz) begin
    if (rst)                     blink_cnt <= '0;
    else if (state_nxt != state) blink_cnt <= '0;
    else if (blink_cnt == BL_LAST) blink_cnt <= '0;
    else                         blink_cnt <= blink_cnt + BL_W'(1);
  end

  assign blink_off = (blink_cnt >= BL_HALF);

  // ---------------------------------------------------------------------
  // Digit selection: pick the source word and a per-digit blank mask from
  // the current mode and blink phase; the digit lanes register the result.
  // ---------------------------------------------------------------------

  // Source mux and blank mask for all six digits.
  always_comb begin
    src_bus   = time_bcd;
    blank_bus = '0;
    case (state)
      M_SW:     src_bus = sw_bcd;
      M_ALMSET: begin
        src_bus = alm_bcd;
        for (int k = 0; k < NUM_DIGITS; k++)
          if (edit_en && blink_off && (edit_pos == 3'(k)))
            blank_bus[k] = 1'b1;
      end
      M_RING:   begin
        src_bus = time_bcd;
        if (blink_off) blank_bus = '1;
      end
      default:  src_bus = time_bcd;
    endcase
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    disp_digit u_digit (
      .clk1khz (clk1khz),
      .rst     (rst),
      .src     (src_bus[k]),
      .blank   (blank_bus[k]),
      .q       (q_bus[k])
    );
  end

  assign q0 = q_bus[0];
  assign q1 = q_bus[1];
  assign q2 = q_bus[2];
  assign q3 = q_bus[3];
  assign q4 = q_bus[4];
  assign q5 = q_bus[5];

endmodule
